seq_add_ctrl: RTL and testbench
===============================

SEQ_ADD_CTRL -- requirements
Module: seq_add_ctrl

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the operand width in 4-bit nibbles (range 2..16).
REQ-002 SHALL have parameter W, default 4*NIBBLES, giving the operand width in bits (derived, not overridable).
REQ-003 clk  input  1  sole clock, rising-edge active.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-006 a  input  W  operand A; captured on the accepted start.
REQ-007 b  input  W  operand B; captured on the accepted start.
REQ-008 c_in  input  1  carry-in; captured on the accepted start.
REQ-009 busy  output  1  high while an operation is in progress (RUN state).
REQ-010 done  output  1  single-cycle pulse marking a valid result.
REQ-011 sum  output  W  result register.
REQ-012 c_out  output  1  final carry register.
REQ-013 add_a  output  4  nibble of A driven to the external 4-bit ripple adder.
REQ-014 add_b  output  4  nibble of B (or its complement) driven to the adder.
REQ-015 add_cin  output  1  carry driven to the adder.
REQ-016 add_sum  input  4  adder sum return; combinational from add_a, add_b and add_cin in the same cycle.
REQ-017 add_cout  input  1  adder carry return; combinational in the same cycle.

Function
REQ-018 FSM SHALL have states IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after the nibble with index NIBBLES-1.
- DONE -> IDLE unconditionally.
REQ-019 On the accepted start SHALL latch a, b and c_in into internal registers, clear the nibble index idx to 0, and load carry_reg with c_in.
REQ-020 In RUN SHALL drive add_a and add_b with operand nibble idx (bits 4*idx+3 down to 4*idx) and drive add_cin from carry_reg.
REQ-021 Each RUN cycle SHALL write add_sum into sum nibble idx, load carry_reg from add_cout, and increment idx.
REQ-022 Outside RUN SHALL drive add_a, add_b and add_cin to 0.
REQ-023 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); c_out SHALL equal carry_reg, registered.
REQ-024 Latency: with start high at edge 0, done SHALL be high during cycle NIBBLES+1 and busy SHALL be high for exactly NIBBLES cycles.
REQ-025 start while in RUN or DONE SHALL be ignored, with no queuing and no operand recapture.
REQ-026 Changes on a, b or c_in after acceptance SHALL NOT affect the result in progress.
REQ-027 sum and c_out SHALL hold their last result until the next accepted start.
REQ-028 On the accepted start, the sum register SHALL clear to 0 so that partial results are visible while busy.
REQ-029 start held high continuously SHALL produce back-to-back operations with exactly one IDLE cycle between done and the next RUN.
REQ-030 The result SHALL be modulo 2^W; overflow appears only on c_out.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, idx=0, carry_reg=0, sum=0, c_out=0, busy=0 and done=0.
REQ-032 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release the block SHALL accept a new start normally.
REQ-033 Operand registers SHALL reset to 0.

Configuration
REQ-034 Macro SEQ_ADD_SUB_EN SHALL, when defined, add input port sub (1 bit), captured on the accepted start.
REQ-035 With SEQ_ADD_SUB_EN defined and sub=1:
- add_b SHALL be the bitwise inverse of the B nibble.
- The initial carry_reg SHALL be 1, and c_in SHALL be ignored.
- The result SHALL be A-B mod 2^W.
- c_out=1 SHALL mean no borrow.
REQ-036 With SEQ_ADD_SUB_EN undefined, port sub SHALL NOT exist and the block SHALL perform addition only.

Verification (NIBBLES=4)
REQ-037 Operation 0x1234+0x4321, c_in=0 -> sum=0x5555, c_out=0; done in cycle 5; busy high for 4 cycles.
REQ-038 Operation 0xFFFF+0x0000, c_in=1 -> sum=0x0000, c_out=1, with the carry rippling through all 4 nibbles.
REQ-039 start pulsed in RUN cycle 2, with a changed to 0xAAAA -> pulse ignored; the original result is unchanged; exactly one done.
REQ-040 rst_n low in RUN cycle 3 -> busy, done, sum and c_out are 0 asynchronously; no done follows; the next operation 0x0001+0x0001 gives 0x0002.
REQ-041 start held high for 3 operations -> three done pulses spaced 6 cycles apart.
REQ-042 SEQ_ADD_SUB_EN defined, sub=1, 0x0005-0x0007 -> sum=0xFFFE, c_out=0; 0x0007-0x0005 -> sum=0x0002, c_out=1.

Source files
------------

// File: rtl/seq_add_ctrl.sv
// Sequential W-bit adder that ripples one nibble per cycle through an external 4-bit adder.
// Optional subtract mode (input sub) is enabled by defining SEQ_ADD_SUB_EN.
module seq_add_ctrl #(
  parameter  int unsigned NIBBLES = 4,
  localparam int unsigned W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
`ifdef SEQ_ADD_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout
);

  localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned SHW  = IDXW + 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            sub_q, sub_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            sub_s;
  logic [SHW-1:0]  sh;
  logic [3:0]      a_nib;
  logic [3:0]      b_nib;

`ifdef SEQ_ADD_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  // Bit offset of the active nibble and the operand nibbles selected by it
  assign sh    = {idx_q, 2'b00};
  assign a_nib = 4'(a_q >> sh);
  assign b_nib = 4'(b_q >> sh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, datapath update and adder drive; busy/done are precomputed from the next state
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b;
          sub_d   = sub_s;
          idx_d   = '0;
          carry_d = sub_s | c_in;
          sum_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        add_a   = a_nib;
        add_b   = sub_q ? ~b_nib : b_nib;
        add_cin = carry_q;
        sum_d   = (sum_q & ~(W'(4'hF) << sh)) | (W'(add_sum) << sh);
        carry_d = add_cout;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == IDXW'(NIBBLES - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign c_out = carry_q;

endmodule

// File: tb/tb_seq_add_ctrl.sv
// Directed bench for seq_add_ctrl (NIBBLES=4) with a behavioural 4-bit adder on the adder port.
// Subtract vectors are included when SEQ_ADD_SUB_EN is defined.
module tb_seq_add_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  int passed;
  int total;

  seq_add_ctrl #(.NIBBLES(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
`ifdef SEQ_ADD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // External ripple adder stand-in
  assign {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One full operation; expects the DUT to be idle at the next falling edge
  task automatic do_op(input vec_t v, input string tag);
    int busy_cnt;
    int done_cnt;
    int done_cyc;
    @(negedge clk);
    a = v.a; b = v.b; c_in = v.cin; sub = v.sub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " sum cleared"}, 64'(sum), 64'h0);
    chk({tag, " add_a nib0"}, 64'(add_a), 64'(v.a[3:0]));
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int k = 1; k <= N + 2; k++) begin
      if (k > 1) @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = k; end
    end
    chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(N));
    chk({tag, " done count"}, 64'(done_cnt), 64'd1);
    chk({tag, " done cycle"}, 64'(done_cyc), 64'(N + 1));
    chk({tag, " sum"}, 64'(sum), 64'(v.sum));
    chk({tag, " c_out"}, 64'(c_out), 64'(v.cout));
  endtask

  initial begin
    int dcnt;
    int dcyc[$];
    vec_t v;
    passed = 0; total = 0;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;

    // Asynchronous reset before the first clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset done", 64'(done), 64'h0);
    chk("reset sum", 64'(sum), 64'h0);
    chk("reset c_out", 64'(c_out), 64'h0);
    chk("reset add_a", 64'(add_a), 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0});
    vecs.push_back('{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1});
    vecs.push_back('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0});
    vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1});
    vecs.push_back('{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1});
    vecs.push_back('{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0});
    vecs.push_back('{16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0});
`ifdef SEQ_ADD_SUB_EN
    vecs.push_back('{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0});
    vecs.push_back('{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1});
    vecs.push_back('{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFF, 1'b1});
`endif

    foreach (vecs[i]) do_op(vecs[i], $sformatf("vec%0d", i));

    chk("idle add_a", 64'(add_a), 64'h0);
    chk("idle add_b", 64'(add_b), 64'h0);
    chk("idle add_cin", 64'(add_cin), 64'h0);
    chk("hold sum", 64'(sum), 64'(vecs[vecs.size()-1].sum));

    // start re-pulsed mid-RUN with a changed operand must be ignored
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1; a = 16'hAAAA;
    @(negedge clk); start = 1'b0;
    dcnt = 0;
    for (int k = 3; k <= 9; k++) begin
      if (k > 3) @(negedge clk);
      if (done) dcnt++;
    end
    chk("ignore start done count", 64'(dcnt), 64'd1);
    chk("ignore start sum", 64'(sum), 64'h5555);
    chk("ignore start c_out", 64'(c_out), 64'h0);

    // Reset asserted in RUN cycle 3 aborts the operation
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; c_in = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("partial sum", 64'(sum), 64'h0055);
    chk("partial busy", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'h0);
    chk("abort done", 64'(done), 64'h0);
    chk("abort sum", 64'(sum), 64'h0);
    chk("abort c_out", 64'(c_out), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    chk("abort no activity", 64'(dcnt), 64'd0);
    v = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0};
    do_op(v, "post reset");

    // start held high: back-to-back operations
    @(negedge clk);
    a = 16'h0F0F; b = 16'h00F1; c_in = 1'b0; start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (done) dcyc.push_back(k);
      if (k == 18) start = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) dcyc.push_back(18 + k);
    end
    chk("b2b done count", 64'(dcyc.size()), 64'd3);
    if (dcyc.size() >= 3) begin
      chk("b2b first done", 64'(dcyc[0]), 64'd5);
      chk("b2b spacing 1", 64'(dcyc[1] - dcyc[0]), 64'd6);
      chk("b2b spacing 2", 64'(dcyc[2] - dcyc[1]), 64'd6);
    end
    chk("b2b sum", 64'(sum), 64'h1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
